multi_debounce_pulse: RTL

MULTI_DEBOUNCE_PULSE -- requirements
Module: multi_debounce_pulse

---
 rtl/multi_debounce_pulse.sv | 130 +++++++++++++
 1 files changed

// File: rtl/multi_debounce_pulse.sv
// Multi-channel debouncer: 2-flop synchronizer, saturating confirm counter, press/release pulses.
// Optional auto-repeat of press pulses while held, enabled by defining AUTO_REPEAT_EN.
module multi_debounce_pulse #(
    parameter int N_CH          = 4,
    parameter int STABLE_CNT    = 4,
    parameter int REPEAT_DELAY  = 8,
    parameter int REPEAT_PERIOD = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] Din,
    output logic [N_CH-1:0] Dout,
    output logic [N_CH-1:0] Rel,
    output logic [N_CH-1:0] Level,
    output logic            Any
);
    localparam int CW = $clog2(STABLE_CNT) + 1;
`ifdef AUTO_REPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int TW   = $clog2(RMAX) + 1;
    typedef enum logic [1:0] {IDLE = 2'd0, HELD = 2'd1, REPEAT = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, HELD = 2'd1} state_t;
`endif

    if (N_CH < 1 || N_CH > 32 || STABLE_CNT < 2 || REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_bad_param
        $error("multi_debounce_pulse: parameter out of range");
    end

    logic [N_CH-1:0] sync1, sync2;
    logic [N_CH-1:0] dout_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= Din;
            sync2 <= sync1;
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        state_t          state_q, state_d;
        logic [CW-1:0]   cnt_q, cnt_d;
        logic            lvl_q, dout_q, rel_q;
        logic            dout_d, rel_d;
`ifdef AUTO_REPEAT_EN
        logic [TW-1:0]   timer_q, timer_d;
`endif

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            dout_d  = 1'b0;
            rel_d   = 1'b0;
`ifdef AUTO_REPEAT_EN
            timer_d = timer_q;
`endif
            if (sync2[g] == lvl_q) begin
                cnt_d = '0;
            end else if (cnt_q < CW'(STABLE_CNT - 1)) begin
                cnt_d = cnt_q + CW'(1);
            end else begin
                cnt_d = '0;
                if (lvl_q) begin
                    state_d = IDLE;
                    rel_d   = 1'b1;
                end else begin
                    state_d = HELD;
                    dout_d  = 1'b1;
                end
            end
`ifdef AUTO_REPEAT_EN
            // A confirmed release wins over a repeat tick landing on the same edge.
            if (rel_d || state_q == IDLE) begin
                timer_d = '0;
            end else if (state_q == HELD) begin
                if (timer_q == TW'(REPEAT_DELAY - 1)) begin
                    timer_d = '0;
                    dout_d  = 1'b1;
                    state_d = REPEAT;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end else begin
                if (timer_q == TW'(REPEAT_PERIOD - 1)) begin
                    timer_d = '0;
                    dout_d  = 1'b1;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
`endif
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state_q <= IDLE;
                cnt_q   <= '0;
                lvl_q   <= 1'b0;
                dout_q  <= 1'b0;
                rel_q   <= 1'b0;
`ifdef AUTO_REPEAT_EN
                timer_q <= '0;
`endif
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                lvl_q   <= (state_d != IDLE);
                dout_q  <= dout_d;
                rel_q   <= rel_d;
`ifdef AUTO_REPEAT_EN
                timer_q <= timer_d;
`endif
            end
        end

        assign dout_nxt[g] = dout_d;
        assign Dout[g]     = dout_q;
        assign Rel[g]      = rel_q;
        assign Level[g]    = lvl_q;
    end

    // Any is built from next-state pulses so it lands on the same edge as Dout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) Any <= 1'b0;
        else     Any <= |dout_nxt;
    end
endmodule
